// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state and owner encodings for the SRAM bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_ACC = 2'd1,
    ST_IF_ACC  = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_bus_timer.sv
// rtl/mem_bus_timer.sv - access latency down-counter, loaded at grant, flags zero
module mem_bus_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Reloaded only at grant and held at zero, so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM bus between fetch and data access, MEM first
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  output logic                bus_ce,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata
);

  arb_state_t state;
  owner_t     owner;
  logic       drop;
  logic       in_acc;
  logic       grant;
  logic       cnt_zero;

  assign in_acc = (state == ST_MEM_ACC) || (state == ST_IF_ACC);
  assign grant  = (state == ST_IDLE) && !flush && (mem_req || if_req);

  mem_bus_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(grant),
    .dec (in_acc),
    .zero(cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      bus_ce    <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          if (!flush && mem_req) begin
            state     <= ST_MEM_ACC;
            owner     <= OWN_MEM;
            bus_ce    <= 1'b1;
            bus_we    <= mem_we;
            bus_be    <= mem_be;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (!flush && if_req) begin
            state     <= ST_IF_ACC;
            owner     <= OWN_IF;
            bus_ce    <= 1'b1;
            bus_we    <= 1'b0;
            bus_be    <= '1;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end
        ST_MEM_ACC, ST_IF_ACC: begin
          if (flush) drop <= 1'b1;
          if (cnt_zero) begin
            bus_ce <= 1'b0;
            bus_we <= 1'b0;
            bus_be <= '0;
            // A flushed access still finishes on the bus, but its result is thrown away.
            if (drop || flush) begin
              state <= ST_IDLE;
              drop  <= 1'b0;
            end else begin
              state <= ST_DONE;
              if (owner == OWN_MEM) mem_rdata <= bus_rdata;
              else                  if_rdata  <= bus_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_stall = mem_req && !((state == ST_DONE) && (owner == OWN_MEM));
  assign if_stall  = if_req  && !((state == ST_DONE) && (owner == OWN_IF));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] bus_rdata;

  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_stall, mem_stall, bus_ce, bus_we;
  logic [3:0]  bus_be;

  logic [31:0] d0_if_rdata, d0_mem_rdata, d0_bus_addr, d0_bus_wdata;
  logic        d0_if_stall, d0_mem_stall, d0_bus_ce, d0_bus_we;
  logic [3:0]  d0_bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(d0_if_rdata), .if_stall(d0_if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(d0_mem_rdata), .mem_stall(d0_mem_stall),
    .bus_ce(d0_bus_ce), .bus_we(d0_bus_we), .bus_be(d0_bus_be), .bus_addr(d0_bus_addr),
    .bus_wdata(d0_bus_wdata), .bus_rdata(bus_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0;
    mem_wdata = '0; bus_rdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_bus_ce", bus_ce, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b0;

    // 1: load, WAIT_CYCLES=2
    tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF;
    mem_addr = 32'h8000_0010; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_c0_stall", mem_stall, 1'b1);
    chk("t1_c0_ce", bus_ce, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick(); @(negedge clk);
      chk("t1_ce", bus_ce, 1'b1);
      chk("t1_addr", bus_addr, 32'h8000_0010);
      chk("t1_we", bus_we, 1'b0);
      chk("t1_stall", mem_stall, 1'b1);
    end
    tick(); @(negedge clk);
    chk("t1_c4_stall", mem_stall, 1'b0);
    chk("t1_c4_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("t1_c4_ce", bus_ce, 1'b0);
    tick();
    mem_req = 1'b0;

    // 2: simultaneous requests, MEM wins
    tick();
    mem_req = 1'b1; if_req = 1'b1; if_addr = 32'h100; mem_addr = 32'h200;
    bus_rdata = 32'h1111_1111;
    for (int c = 1; c <= 3; c++) begin
      tick(); @(negedge clk);
      chk("t2_mem_ce", bus_ce, 1'b1);
      chk("t2_mem_addr", bus_addr, 32'h200);
      chk("t2_if_stall", if_stall, 1'b1);
    end
    tick(); @(negedge clk);
    chk("t2_c4_mem_stall", mem_stall, 1'b0);
    chk("t2_c4_if_stall", if_stall, 1'b1);
    chk("t2_c4_mem_rdata", mem_rdata, 32'h1111_1111);
    tick();
    mem_req = 1'b0; bus_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("t2_c5_idle_ce", bus_ce, 1'b0);
    chk("t2_c5_if_stall", if_stall, 1'b1);
    for (int c = 6; c <= 8; c++) begin
      tick(); @(negedge clk);
      chk("t2_if_ce", bus_ce, 1'b1);
      chk("t2_if_addr", bus_addr, 32'h100);
      chk("t2_if_be", bus_be, 4'hF);
      chk("t2_if_stall_acc", if_stall, 1'b1);
    end
    tick(); @(negedge clk);
    chk("t2_c9_if_stall", if_stall, 1'b0);
    chk("t2_c9_if_rdata", if_rdata, 32'h2222_2222);
    tick();
    if_req = 1'b0;

    // 3: flushed store still writes, DONE skipped
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h300;
    mem_wdata = 32'hCAFE_F00D; bus_rdata = 32'h3333_3333;
    for (int c = 1; c <= 3; c++) begin
      tick();
      flush = (c == 2);
      @(negedge clk);
      chk("t3_ce", bus_ce, 1'b1);
      chk("t3_we", bus_we, 1'b1);
      chk("t3_be", bus_be, 4'b0011);
      chk("t3_wdata", bus_wdata, 32'hCAFE_F00D);
    end
    tick(); @(negedge clk);
    chk("t3_c4_ce", bus_ce, 1'b0);
    chk("t3_c4_we", bus_we, 1'b0);
    chk("t3_c4_stall", mem_stall, 1'b1);
    chk("t3_c4_rdata", mem_rdata, 32'h1111_1111);
    mem_req = 1'b0; mem_we = 1'b0;
    tick(); @(negedge clk);
    chk("t3_c5_ce", bus_ce, 1'b0);

    // 4: flushed fetch, new address fetched from the following IDLE
    tick();
    if_req = 1'b1; if_addr = 32'h400; bus_rdata = 32'h4444_4444;
    for (int c = 1; c <= 3; c++) begin
      tick();
      flush = (c == 2);
      @(negedge clk);
      chk("t4_ce", bus_ce, 1'b1);
      chk("t4_addr", bus_addr, 32'h400);
    end
    tick();
    @(negedge clk);
    chk("t4_c4_ce", bus_ce, 1'b0);
    chk("t4_c4_stall", if_stall, 1'b1);
    chk("t4_c4_rdata", if_rdata, 32'h2222_2222);
    if_addr = 32'h500;
    for (int c = 5; c <= 7; c++) begin
      tick(); @(negedge clk);
      chk("t4_new_ce", bus_ce, 1'b1);
      chk("t4_new_addr", bus_addr, 32'h500);
    end
    tick(); @(negedge clk);
    chk("t4_c8_stall", if_stall, 1'b0);
    chk("t4_c8_rdata", if_rdata, 32'h4444_4444);
    tick();
    if_req = 1'b0;

    // 5: reset mid-access
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 32'h600;
    mem_wdata = 32'h1234_5678;
    tick(); @(negedge clk);
    chk("t5_c1_ce", bus_ce, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_c2_ce", bus_ce, 1'b1);
    tick();
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("t5_c3_ce", bus_ce, 1'b0);
    chk("t5_c3_we", bus_we, 1'b0);
    chk("t5_c3_be", bus_be, 4'h0);
    chk("t5_c3_addr", bus_addr, 32'h0);
    chk("t5_c3_wdata", bus_wdata, 32'h0);
    chk("t5_c3_mem_rdata", mem_rdata, 32'h0);
    chk("t5_c3_if_rdata", if_rdata, 32'h0);
    chk("t5_c3_stall", mem_stall, 1'b0);

    // 6: WAIT_CYCLES=0 instance
    tick();
    mem_req = 1'b1; mem_addr = 32'h700; mem_be = 4'hF; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("t6_c0_stall", d0_mem_stall, 1'b1);
    tick(); @(negedge clk);
    chk("t6_c1_ce", d0_bus_ce, 1'b1);
    chk("t6_c1_addr", d0_bus_addr, 32'h700);
    chk("t6_c1_stall", d0_mem_stall, 1'b1);
    tick(); @(negedge clk);
    chk("t6_c2_ce", d0_bus_ce, 1'b0);
    chk("t6_c2_stall", d0_mem_stall, 1'b0);
    chk("t6_c2_rdata", d0_mem_rdata, 32'h7777_7777);
    tick();
    mem_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
